f_imem_resp: RTL and testbench

- Instruction-memory responder at the fetch-stage boundary; serves the fetch address that the PC register issues each cycle.
- Accepts one fetch request at a time via valid/ready, returns the instruction word after a fixed latency, and holds the response until the consumer accepts it.
- Supports a flush from branch/jump redirect and a program-load write port used by the bench.

---
 rtl/f_imem_resp.sv | 109 ++++++++++
 tb/tb_f_imem_resp.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_imem_resp.sv
// rtl/f_imem_resp.sv - fetch-stage instruction memory responder with fixed latency, flush and load port
module f_imem_resp #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 1,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req_valid,
    input  logic [31:0]   i_req_addr,
    output logic          o_req_ready,
    output logic          o_resp_valid,
    output logic [31:0]   o_resp_instr,
    output logic [31:0]   o_resp_pc,
    output logic          o_resp_err,
    input  logic          i_resp_ready,
    input  logic          i_flush,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_idx,
    input  logic [31:0]   i_ld_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // State entered on accept, and the countdown preload when WAIT is used.
    localparam logic [1:0] S_ACC    = (LATENCY == 1) ? S_RESP : S_WAIT;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        err_q;

    logic [31:0] offset;
    logic [31:0] word_idx;
    logic        req_err;
    logic        accept;

    assign offset   = i_req_addr - BASE_ADDR;
    assign word_idx = offset >> 2;
    assign req_err  = (i_req_addr[1:0] != 2'b00) || (i_req_addr < BASE_ADDR)
                   || (word_idx >= 32'(DEPTH));

    assign o_req_ready  = ((state == S_IDLE) || ((state == S_RESP) && i_resp_ready)) && !i_flush;
    assign accept       = i_req_valid && o_req_ready;
    assign o_resp_valid = (state == S_RESP);
    assign o_resp_instr = instr_q;
    assign o_resp_pc    = pc_q;
    assign o_resp_err   = err_q;

    // Load writes are independent of the fetch state; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (i_ld_en) begin
            mem[i_ld_idx] <= i_ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                pc_q    <= i_req_addr;
                err_q   <= req_err;
                instr_q <= req_err ? 32'd0 : mem[word_idx[AW-1:0]];
            end
            if (i_flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            state <= S_ACC;
                            cnt   <= CNT_INIT;
                        end
                    end
                    S_WAIT: begin
                        if (cnt == 4'd0) begin
                            state <= S_RESP;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_RESP: begin
                        if (i_resp_ready) begin
                            if (accept) begin
                                state <= S_ACC;
                                cnt   <= CNT_INIT;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_f_imem_resp.sv
// tb/tb_f_imem_resp.sv - scoreboard bench for f_imem_resp at LATENCY 1 and 3 sharing one stimulus
module tb_f_imem_resp;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_resp_ready;
    logic        i_flush;
    logic        i_ld_en;
    logic [11:0] i_ld_idx;
    logic [31:0] i_ld_data;

    logic        o1_req_ready, o1_resp_valid, o1_resp_err;
    logic [31:0] o1_resp_instr, o1_resp_pc;
    logic        o3_req_ready, o3_resp_valid, o3_resp_err;
    logic [31:0] o3_resp_instr, o3_resp_pc;

    logic [31:0] model_mem [4096];
    resp_t       sbq [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    f_imem_resp #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
        .o_req_ready(o1_req_ready), .o_resp_valid(o1_resp_valid), .o_resp_instr(o1_resp_instr),
        .o_resp_pc(o1_resp_pc), .o_resp_err(o1_resp_err), .i_resp_ready(i_resp_ready),
        .i_flush(i_flush), .i_ld_en(i_ld_en), .i_ld_idx(i_ld_idx), .i_ld_data(i_ld_data)
    );

    f_imem_resp #(.LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
        .o_req_ready(o3_req_ready), .o_resp_valid(o3_resp_valid), .o_resp_instr(o3_resp_instr),
        .o_resp_pc(o3_resp_pc), .o_resp_err(o3_resp_err), .i_resp_ready(i_resp_ready),
        .i_flush(i_flush), .i_ld_en(i_ld_en), .i_ld_idx(i_ld_idx), .i_ld_data(i_ld_data)
    );

    function automatic resp_t model(input logic [31:0] a);
        resp_t       r;
        logic [31:0] wi;
        wi      = (a - 32'h3000) >> 2;
        r.pc    = a;
        r.err   = (a[1:0] != 2'b00) || (a < 32'h3000) || (wi >= 32'd4096);
        r.instr = r.err ? 32'd0 : model_mem[wi[11:0]];
        return r;
    endfunction

    task automatic idle_inputs();
        i_req_valid  = 1'b0;
        i_req_addr   = 32'd0;
        i_resp_ready = 1'b0;
        i_flush      = 1'b0;
        i_ld_en      = 1'b0;
        i_ld_idx     = 12'd0;
        i_ld_data    = 32'd0;
    endtask

    task automatic reset_all();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
    endtask

    task automatic load(input logic [11:0] idx, input logic [31:0] d);
        @(negedge clk);
        i_ld_en   = 1'b1;
        i_ld_idx  = idx;
        i_ld_data = d;
        model_mem[idx] = d;
        @(negedge clk);
        i_ld_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({o1_resp_valid, o1_resp_instr, o1_resp_pc, o1_resp_err} !== 66'd0) begin
            errors++;
            $display("FAIL reset_out1: got %h expected 0", {o1_resp_valid, o1_resp_instr, o1_resp_pc, o1_resp_err});
        end
        checks++;
        if ({o3_resp_valid, o3_resp_instr, o3_resp_pc, o3_resp_err} !== 66'd0) begin
            errors++;
            $display("FAIL reset_out3: got %h expected 0", {o3_resp_valid, o3_resp_instr, o3_resp_pc, o3_resp_err});
        end
        checks++;
        if ({o1_req_ready, o3_req_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 11", {o1_req_ready, o3_req_ready});
        end
    endtask

    task automatic test_basic();
        logic [31:0] addrs [2];
        resp_t e, got;
        addrs[0] = 32'h3000;
        addrs[1] = 32'h3004;
        reset_all();
        load(12'd0, 32'h3c01_1234);
        load(12'd1, 32'h3421_5678);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            i_req_valid  = (c < 2);
            i_req_addr   = (c < 2) ? addrs[c] : 32'd0;
            i_resp_ready = 1'b1;
            #1;
            if (c < 2) begin
                checks++;
                if (o1_req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_ready c=%0d: got %b expected 1", c, o1_req_ready);
                end
                if (o1_req_ready) sbq.push_back(model(addrs[c]));
            end
            if (c > 0) begin
                checks++;
                if (o1_resp_valid !== 1'b1 || sbq.size() == 0) begin
                    errors++;
                    $display("FAIL basic_valid c=%0d: got %b expected 1", c, o1_resp_valid);
                end else begin
                    e   = sbq.pop_front();
                    got = '{o1_resp_pc, o1_resp_instr, o1_resp_err};
                    checks++;
                    if (got !== e) begin
                        errors++;
                        $display("FAIL basic_resp c=%0d: got %h expected %h", c, got, e);
                    end
                end
            end
        end
        @(negedge clk);
        i_req_valid = 1'b0;
        #1;
        checks++;
        if (o1_resp_valid !== 1'b0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: got valid=%b pending=%0d expected 0/0", o1_resp_valid, sbq.size());
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic        experr [4];
        resp_t e, got;
        addrs[0] = 32'h3002; experr[0] = 1'b1;
        addrs[1] = 32'h2ffc; experr[1] = 1'b1;
        addrs[2] = 32'h7000; experr[2] = 1'b1;
        addrs[3] = 32'h6ffc; experr[3] = 1'b0;
        reset_all();
        load(12'd4095, 32'h0bad_f00d);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_req_valid  = 1'b1;
            i_req_addr   = addrs[i];
            i_resp_ready = 1'b1;
            #1;
            if (o1_req_ready) sbq.push_back(model(addrs[i]));
            @(negedge clk);
            i_req_valid = 1'b0;
            #1;
            checks++;
            if (o1_resp_valid !== 1'b1 || sbq.size() == 0) begin
                errors++;
                $display("FAIL err_valid %h: got %b expected 1", addrs[i], o1_resp_valid);
            end else begin
                e   = sbq.pop_front();
                got = '{o1_resp_pc, o1_resp_instr, o1_resp_err};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL err_resp %h: got %h expected %h", addrs[i], got, e);
                end
                checks++;
                if (o1_resp_err !== experr[i] || o1_resp_instr !== (experr[i] ? 32'd0 : 32'h0bad_f00d)) begin
                    errors++;
                    $display("FAIL err_flag %h: got err=%b instr=%h expected err=%b", addrs[i], o1_resp_err, o1_resp_instr, experr[i]);
                end
            end
        end
    endtask

    task automatic test_latency();
        resp_t e, got;
        reset_all();
        load(12'd2, 32'h1111_2222);
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_req_addr   = 32'h3008;
        i_resp_ready = 1'b0;
        #1;
        checks++;
        if (o3_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_accept: got %b expected 1", o3_req_ready);
        end
        if (o3_req_ready) sbq.push_back(model(32'h3008));
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            i_req_valid  = 1'b0;
            i_resp_ready = (k == 7);
            i_ld_en      = (k == 4);
            i_ld_idx     = 12'd2;
            i_ld_data    = 32'h5555_aaaa;
            if (k == 4) model_mem[2] = 32'h5555_aaaa;
            #1;
            checks++;
            if (o3_resp_valid !== (k >= 3 && k <= 7)) begin
                errors++;
                $display("FAIL lat_valid k=%0d: got %b expected %b", k, o3_resp_valid, (k >= 3 && k <= 7));
            end
            if (k <= 7) begin
                checks++;
                if (o3_req_ready !== (k == 7)) begin
                    errors++;
                    $display("FAIL lat_ready k=%0d: got %b expected %b", k, o3_req_ready, (k == 7));
                end
            end
            if (k >= 3 && k <= 7 && sbq.size() != 0) begin
                e   = (k == 7) ? sbq.pop_front() : sbq[0];
                got = '{o3_resp_pc, o3_resp_instr, o3_resp_err};
                checks++;
                if (got !== e || o3_resp_instr !== 32'h1111_2222) begin
                    errors++;
                    $display("FAIL lat_hold k=%0d: got %h expected %h", k, got, e);
                end
            end
        end
        i_ld_en = 1'b0;
    endtask

    task automatic test_flush_wait();
        resp_t e, got;
        reset_all();
        load(12'd4, 32'h4444_0004);
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            i_req_valid  = (k == 0) || (k == 3);
            i_req_addr   = (k == 0) ? 32'h3008 : 32'h3010;
            i_resp_ready = (k >= 3);
            i_flush      = (k == 2);
            #1;
            if (k == 2) begin
                checks++;
                if (o3_req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fw_ready_flush: got %b expected 0", o3_req_ready);
                end
            end
            if (k == 3) begin
                checks++;
                if (o3_req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL fw_ready_idle: got %b expected 1", o3_req_ready);
                end
                if (o3_req_ready) sbq.push_back(model(32'h3010));
            end
            checks++;
            if (o3_resp_valid !== (k == 6)) begin
                errors++;
                $display("FAIL fw_valid k=%0d: got %b expected %b", k, o3_resp_valid, (k == 6));
            end else if (k == 6 && sbq.size() != 0) begin
                e   = sbq.pop_front();
                got = '{o3_resp_pc, o3_resp_instr, o3_resp_err};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL fw_resp: got %h expected %h", got, e);
                end
            end
        end
        i_flush = 1'b0;
    endtask

    task automatic test_flush_resp();
        reset_all();
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_req_addr   = 32'h3000;
        i_resp_ready = 1'b0;
        @(negedge clk);
        i_flush      = 1'b1;
        i_resp_ready = 1'b1;
        i_req_addr   = 32'h3004;
        #1;
        checks++;
        if (o1_req_ready !== 1'b0 || o1_resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL fr_flush_cycle: got ready=%b valid=%b expected 0/1", o1_req_ready, o1_resp_valid);
        end
        @(negedge clk);
        i_flush     = 1'b0;
        i_req_valid = 1'b0;
        #1;
        checks++;
        if (o1_resp_valid !== 1'b0 || o1_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL fr_after: got valid=%b ready=%b expected 0/1", o1_resp_valid, o1_req_ready);
        end
    endtask

    task automatic test_reset_mid();
        resp_t e, got;
        reset_all();
        load(12'd5, 32'h5050_0505);
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_req_addr   = 32'h3014;
        i_resp_ready = 1'b0;
        @(negedge clk);
        i_req_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({o3_resp_valid, o3_resp_instr, o3_resp_pc, o3_resp_err} !== 66'd0 || o3_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rm_outputs: got %h ready=%b expected 0 ready=1",
                     {o3_resp_valid, o3_resp_instr, o3_resp_pc, o3_resp_err}, o3_req_ready);
        end
        for (int k = 3; k <= 9; k++) begin
            @(negedge clk);
            i_req_valid  = (k == 6);
            i_resp_ready = 1'b1;
            #1;
            if (k == 6 && o3_req_ready) sbq.push_back(model(32'h3014));
            checks++;
            if (o3_resp_valid !== (k == 9)) begin
                errors++;
                $display("FAIL rm_valid k=%0d: got %b expected %b", k, o3_resp_valid, (k == 9));
            end else if (k == 9 && sbq.size() != 0) begin
                e   = sbq.pop_front();
                got = '{o3_resp_pc, o3_resp_instr, o3_resp_err};
                checks++;
                if (got !== e || o3_resp_instr !== 32'h5050_0505) begin
                    errors++;
                    $display("FAIL rm_mem_kept: got %h expected %h", got, e);
                end
            end
        end
    endtask

    task automatic test_rbw();
        resp_t e, got;
        logic [31:0] want [3];
        want[1] = 32'h3c01_1234;
        want[2] = 32'hdead_beef;
        reset_all();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            i_req_valid  = (c < 2);
            i_req_addr   = 32'h3000;
            i_resp_ready = 1'b1;
            i_ld_en      = (c == 0);
            i_ld_idx     = 12'd0;
            i_ld_data    = 32'hdead_beef;
            #1;
            if (c < 2 && o1_req_ready) sbq.push_back(model(32'h3000));
            if (c == 0) model_mem[0] = 32'hdead_beef;
            if (c > 0) begin
                checks++;
                if (o1_resp_valid !== 1'b1 || sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rbw_valid c=%0d: got %b expected 1", c, o1_resp_valid);
                end else begin
                    e   = sbq.pop_front();
                    got = '{o1_resp_pc, o1_resp_instr, o1_resp_err};
                    checks++;
                    if (got !== e || o1_resp_instr !== want[c]) begin
                        errors++;
                        $display("FAIL rbw_resp c=%0d: got %h expected %h", c, got, e);
                    end
                end
            end
        end
        i_ld_en     = 1'b0;
        i_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_latency();
        test_flush_wait();
        test_flush_resp();
        test_reset_mid();
        test_rbw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
